// File: rtl/axis_width_up.sv
// AXI4-Stream width up-converter: packs RATIO beats of IN_W bits into one word with per-lane tkeep.
// One-cycle latency from the completing beat; s_axis_tready drops only while an output word is held.
module axis_width_up #(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [IN_W-1:0]       s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [IN_W*RATIO-1:0] m_axis_tdata,
  output logic [RATIO-1:0]      m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int AW    = (RATIO > 1) ? RATIO - 1 : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

  logic [CW-1:0]              cnt;
  logic [AW-1:0][IN_W-1:0]    acc;
  logic [RATIO-1:0][IN_W-1:0] beat;
  logic [OUT_W-1:0]           word_dat;
  logic [RATIO-1:0]           word_keep;
  logic                       accept;
  logic                       complete;

  assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign complete      = (cnt == CNT_MAX) | s_axis_tlast;

  // beat[j] is the j-th beat of the word in arrival order; lanes past cnt stay zero
  for (genvar j = 0; j < RATIO; j++) begin : g_lane
    localparam int LANE = MSB_FIRST ? RATIO - 1 - j : j;
    if (j < RATIO - 1) begin : g_acc
      assign beat[j] = (CW'(j) < cnt)  ? acc[j] :
                       (CW'(j) == cnt) ? s_axis_tdata : '0;
    end else begin : g_cur
      assign beat[j] = (CW'(j) == cnt) ? s_axis_tdata : '0;
    end
    assign word_dat[LANE*IN_W +: IN_W] = beat[j];
    assign word_keep[LANE]             = (CW'(j) <= cnt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt           <= '0;
      acc           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (accept) begin
        if (complete) begin
          cnt           <= '0;
          acc           <= '0;
          m_axis_tdata  <= word_dat;
          m_axis_tkeep  <= word_keep;
          m_axis_tlast  <= s_axis_tlast;
          m_axis_tvalid <= 1'b1;
        end else begin
          acc[cnt] <= s_axis_tdata;
          cnt      <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_width_up.sv
// Bench for axis_width_up: MSB-first and LSB-first 8x4 instances plus a 16-bit RATIO=1 instance.
module tb_axis_width_up;

  typedef struct packed {
    logic [31:0] md;
    logic [3:0]  mk;
    logic [31:0] ld;
    logic [3:0]  lk;
    logic        last;
  } w_t;

  typedef struct packed {
    logic [15:0] d;
    logic        last;
  } r_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  s_dat;
  logic        s_vld;
  logic        s_last;
  logic        m_rdy;
  int          rdy_mode;

  logic        s_rdy, l_srdy, r_srdy;
  logic [31:0] m_dat, l_dat;
  logic [3:0]  m_keep, l_keep;
  logic        m_vld, l_vld, m_last, l_last;
  logic [15:0] r_sdat, r_mdat;
  logic [0:0]  r_mkeep;
  logic        r_mvld, r_mlast;

  int n_cmp = 0;
  int n_bad = 0;

  w_t         exp_q[$];
  w_t         got[$];
  logic [7:0] part[$];
  r_t         r1_q[$];
  bit         loaded, held, r1_loaded, r1_held;
  w_t         h_w;
  r_t         r1_h;

  assign r_sdat = {s_dat, ~s_dat};

  always #5 clk = ~clk;

  axis_width_up #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tdata(s_dat), .s_axis_tvalid(s_vld), .s_axis_tlast(s_last), .s_axis_tready(s_rdy),
    .m_axis_tdata(m_dat), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_vld), .m_axis_tlast(m_last),
    .m_axis_tready(m_rdy)
  );

  axis_width_up #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tdata(s_dat), .s_axis_tvalid(s_vld), .s_axis_tlast(s_last), .s_axis_tready(l_srdy),
    .m_axis_tdata(l_dat), .m_axis_tkeep(l_keep), .m_axis_tvalid(l_vld), .m_axis_tlast(l_last),
    .m_axis_tready(m_rdy)
  );

  axis_width_up #(.IN_W(16), .RATIO(1), .MSB_FIRST(1'b1)) u_r1 (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tdata(r_sdat), .s_axis_tvalid(s_vld), .s_axis_tlast(s_last), .s_axis_tready(r_srdy),
    .m_axis_tdata(r_mdat), .m_axis_tkeep(r_mkeep), .m_axis_tvalid(r_mvld), .m_axis_tlast(r_mlast),
    .m_axis_tready(m_rdy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Scoreboard: words are formed from the accepted beat list by plain shifting
  always @(negedge clk) begin
    w_t e;
    r_t re;
    if (!reset_n) begin
      exp_q.delete(); part.delete(); r1_q.delete();
      loaded = 0; held = 0; r1_loaded = 0; r1_held = 0;
    end else begin
      chk("s_tready_rule", s_rdy, !m_vld || m_rdy);
      chk("lsb_tready", l_srdy, s_rdy);
      chk("lsb_tvalid", l_vld, m_vld);
      if (loaded) begin
        e = exp_q[$];
        chk("load_vld", m_vld, 1);
        chk("load_dat", m_dat, e.md);
        chk("load_keep", m_keep, e.mk);
      end
      if (held) begin
        chk("hold_vld", m_vld, 1);
        chk("hold_dat", m_dat, h_w.md);
        chk("hold_keep", m_keep, h_w.mk);
        chk("hold_last", m_last, h_w.last);
      end
      if (m_vld && m_rdy) begin
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("msb_dat", m_dat, e.md);
          chk("msb_keep", m_keep, e.mk);
          chk("lsb_dat", l_dat, e.ld);
          chk("lsb_keep", l_keep, e.lk);
          chk("msb_last", m_last, e.last);
          chk("lsb_last", l_last, e.last);
        end
        got.push_back('{md: m_dat, mk: m_keep, ld: l_dat, lk: l_keep, last: m_last});
      end
      held = m_vld && !m_rdy;
      h_w  = '{md: m_dat, mk: m_keep, ld: l_dat, lk: l_keep, last: m_last};
      loaded = 0;
      if (s_vld && s_rdy) begin
        part.push_back(s_dat);
        if (part.size() == 4 || s_last) begin
          e = '0;
          e.last = s_last;
          for (int i = 0; i < part.size(); i++) begin
            e.md = e.md | (32'(part[i]) << (8 * (3 - i)));
            e.mk[3 - i] = 1'b1;
            e.ld = e.ld | (32'(part[i]) << (8 * i));
            e.lk[i] = 1'b1;
          end
          exp_q.push_back(e);
          part.delete();
          loaded = 1;
        end
      end

      chk("r1_tready_rule", r_srdy, !r_mvld || m_rdy);
      if (r1_loaded) begin
        chk("r1_load_vld", r_mvld, 1);
        chk("r1_load_dat", r_mdat, r1_q[$].d);
      end
      if (r1_held) begin
        chk("r1_hold_dat", r_mdat, r1_h.d);
        chk("r1_hold_vld", r_mvld, 1);
      end
      if (r_mvld && m_rdy) begin
        chk("r1_word_expected", r1_q.size() != 0, 1);
        chk("r1_keep", r_mkeep, 1);
        if (r1_q.size() != 0) begin
          re = r1_q.pop_front();
          chk("r1_dat", r_mdat, re.d);
          chk("r1_last", r_mlast, re.last);
        end
      end
      r1_held   = r_mvld && !m_rdy;
      r1_h      = '{d: r_mdat, last: r_mlast};
      r1_loaded = 0;
      if (s_vld && r_srdy) begin
        r1_q.push_back('{d: r_sdat, last: s_last});
        r1_loaded = 1;
      end
    end
  end

  initial begin
    m_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom % 2);
    end
  end

  task automatic put(input logic [7:0] b, input bit last, output int tries);
    bit ok;
    tries = 0;
    s_vld = 1'b1; s_dat = b; s_last = last;
    do begin
      @(negedge clk);
      ok = s_rdy;
      @(posedge clk);
      #1;
      tries++;
    end while (!ok && tries < 200);
    if (!ok) chk("put_timeout", 0, 1);
    s_vld = 1'b0; s_last = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || r1_q.size() != 0 || m_vld || r_mvld) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_done", t < 500, 1);
  endtask

  task automatic reset_pulse();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_vld_drop", m_vld, 0);
    chk("rst_dat_zero", m_dat, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input int idx, input logic [31:0] md, input logic [3:0] mk,
                     input logic [31:0] ld, input logic [3:0] lk, input bit last);
    chk("log_entry_present", idx < got.size(), 1);
    if (idx < got.size()) begin
      chk("lit_msb_dat", got[idx].md, md);
      chk("lit_msb_keep", got[idx].mk, mk);
      chk("lit_lsb_dat", got[idx].ld, ld);
      chk("lit_lsb_keep", got[idx].lk, lk);
      chk("lit_last", got[idx].last, last);
    end
  endtask

  initial begin
    int tr, tsum, len, t;
    reset_n = 1'b0; s_vld = 1'b0; s_dat = '0; s_last = 1'b0; rdy_mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_m_vld", m_vld, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_keep", m_keep, 0);
    chk("rst_m_dat", m_dat, 0);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_s_rdy", s_rdy, 1);

    // 8 bytes, tlast on the 8th
    got.delete(); tsum = 0;
    for (int i = 1; i <= 8; i++) begin put(8'(i), i == 8, tr); tsum += tr; end
    drain();
    chk("no_stall_cycles", tsum, 8);
    chk("t1_words", got.size(), 2);
    lit(0, 32'h01020304, 4'hF, 32'h04030201, 4'hF, 0);
    lit(1, 32'h05060708, 4'hF, 32'h08070605, 4'hF, 1);

    // 5 bytes, then 1-byte and 3-byte packets
    got.delete();
    for (int i = 1; i <= 5; i++) put(8'(i), i == 5, tr);
    put(8'hAA, 1, tr);
    put(8'h11, 0, tr); put(8'h22, 0, tr); put(8'h33, 1, tr);
    drain();
    chk("t2_words", got.size(), 4);
    lit(0, 32'h01020304, 4'hF, 32'h04030201, 4'hF, 0);
    lit(1, 32'h05000000, 4'h8, 32'h00000005, 4'h1, 1);
    lit(2, 32'hAA000000, 4'h8, 32'h000000AA, 4'h1, 1);
    lit(3, 32'h11223300, 4'hE, 32'h00332211, 4'h7, 1);

    // Backpressure for 10 cycles once the first word appears
    got.delete();
    rdy_mode = 1;
    fork
      for (int i = 1; i <= 12; i++) put(8'(i), i == 12, tr);
      begin
        t = 0;
        while (!m_vld && t < 100) begin @(negedge clk); t++; end
        chk("bp_first_word", m_vld, 1);
        repeat (10) @(negedge clk);
        chk("bp_s_rdy_low", s_rdy, 0);
        chk("bp_dat_stable", m_dat, 32'h01020304);
        rdy_mode = 0;
      end
    join
    drain();
    chk("bp_words", got.size(), 3);
    lit(0, 32'h01020304, 4'hF, 32'h04030201, 4'hF, 0);
    lit(1, 32'h05060708, 4'hF, 32'h08070605, 4'hF, 0);
    lit(2, 32'h090A0B0C, 4'hF, 32'h0C0B0A09, 4'hF, 1);

    // Reset with a held output word, then with a partial word
    got.delete();
    rdy_mode = 1;
    for (int i = 1; i <= 4; i++) put(8'(i), 0, tr);
    chk("pending_before_rst", m_vld, 1);
    reset_pulse();
    rdy_mode = 0;
    put(8'h11, 0, tr); put(8'h22, 0, tr);
    reset_pulse();
    put(8'h0A, 0, tr); put(8'h0B, 0, tr); put(8'h0C, 0, tr); put(8'h0D, 1, tr);
    drain();
    chk("rst_words", got.size(), 1);
    lit(0, 32'h0A0B0C0D, 4'hF, 32'h0D0C0B0A, 4'hF, 1);

    // Random packets under 50% output backpressure
    rdy_mode = 2;
    for (int p = 0; p < 1000; p++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        put(8'($urandom), i == len - 1, tr);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rdy_mode = 0;
    drain();
    chk("final_partial_empty", part.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
